// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: stage payload structs, handshake register state and flush control.
// Imported by every inter-stage register and by the hazard unit.
package pipe_stage_reg_pkg;

    localparam int unsigned XLen      = 32;
    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned NumStages = 4;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_TWO
    } pipe_state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_BRANCH_MISPREDICT,
        ERR_EXCEPTION,
        ERR_INTERRUPT,
        ERR_FENCE
    } error_t;

    // Per-stage flush request driven by the hazard unit.
    typedef struct packed {
        logic   flush;
        error_t cause;
    } pipe_flush_t;

    typedef struct packed {
        logic [XLen-1:0] pc;
        logic [XLen-1:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [XLen-1:0]     pc;
        logic [XLen-1:0]     rs1_val;
        logic [XLen-1:0]     rs2_val;
        logic [XLen-1:0]     imm;
        logic [RegAddrW-1:0] rd;
        logic [3:0]          alu_op;
        logic                reg_we;
        logic                mem_re;
        logic                mem_we;
    } decode_data_t;

    typedef struct packed {
        logic [XLen-1:0]     result;
        logic [XLen-1:0]     store_val;
        logic [RegAddrW-1:0] rd;
        logic                reg_we;
        logic                mem_re;
        logic                mem_we;
    } execute_data_t;

    typedef struct packed {
        logic [XLen-1:0]     result;
        logic [RegAddrW-1:0] rd;
        logic                reg_we;
    } memory_data_t;

    function automatic logic [1:0] state_occupancy(pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            PS_EMPTY: occ = 2'd0;
            PS_ONE:   occ = 2'd1;
            PS_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Reusable for stall and other performance counters.
module sat_counter #(
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNTW{1'b1}})) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned W    = 64,
    parameter int unsigned SKID = 1,
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    input  logic            flush,
    output logic [1:0]      occupancy,
    output logic [CNTW-1:0] stall_cnt
);

    logic in_fire;
    logic out_fire;
    logic stall_inc;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready && !flush;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t state_q, state_d;
            logic [W-1:0] main_q, main_d;
            logic [W-1:0] skid_q, skid_d;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    // Payloads keep their value; only the occupancy is discarded.
                    state_d = PS_EMPTY;
                end else begin
                    unique case (state_q)
                        PS_EMPTY: begin
                            if (in_fire) begin
                                main_d  = in_data;
                                state_d = PS_ONE;
                            end
                        end
                        PS_ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (in_fire) begin
                                skid_d  = in_data;
                                state_d = PS_TWO;
                            end else if (out_fire) begin
                                state_d = PS_EMPTY;
                            end
                        end
                        PS_TWO: begin
                            if (out_fire) begin
                                main_d  = skid_q;
                                state_d = PS_ONE;
                            end
                        end
                        default: state_d = PS_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= PS_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            assign in_ready  = (state_q != PS_TWO);
            assign out_valid = (state_q != PS_EMPTY);
            assign out_data  = main_q;
            assign occupancy = state_occupancy(state_q);
        end else begin : g_single
            logic         valid_q, valid_d;
            logic [W-1:0] main_q, main_d;

            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (in_fire) begin
                    main_d  = in_data;
                    valid_d = 1'b1;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end

            // Sole combinational path through the block: out_ready -> in_ready.
            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

    sat_counter #(
        .CNTW(CNTW)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (index 0), single-register (1) and 4-bit counter (2) instances,
// all checked against a queue model of held beats.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] out_data  [3];
    logic        flush     [3];
    logic [1:0]  occ       [3];
    logic [31:0] st_skid;
    logic [31:0] st_single;
    logic [3:0]  st_sat;

    int errors;
    int checks;

    // Reference model: FIFO of held beats and stall count per instance.
    logic [15:0] mq [3][$];
    int unsigned cnt_m [3];
    int unsigned cnt_cap [3];

    pipe_stage_reg #(.W(16), .SKID(1), .CNTW(32)) dut_skid (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .flush(flush[0]), .occupancy(occ[0]), .stall_cnt(st_skid)
    );

    pipe_stage_reg #(.W(16), .SKID(0), .CNTW(32)) dut_single (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .flush(flush[1]), .occupancy(occ[1]), .stall_cnt(st_single)
    );

    pipe_stage_reg #(.W(16), .SKID(1), .CNTW(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .flush(flush[2]), .occupancy(occ[2]), .stall_cnt(st_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stall_of(input int i);
        if (i == 0) return st_skid;
        if (i == 1) return st_single;
        return {28'd0, st_sat};
    endfunction

    function automatic logic model_ready(input int i);
        if (i == 1) return (mq[i].size() == 0) || out_ready[i];
        return mq[i].size() < 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            cnt_m[i] = 0;
        end
    endtask

    task automatic compare_all(input string ph);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s%0d_ov", ph, i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
            if (mq[i].size() > 0)
                check($sformatf("%s%0d_data", ph, i), 32'(out_data[i]), 32'(mq[i][0]));
            check($sformatf("%s%0d_ir", ph, i), 32'(in_ready[i]), 32'(model_ready(i)));
            check($sformatf("%s%0d_occ", ph, i), 32'(occ[i]), mq[i].size());
            check($sformatf("%s%0d_stall", ph, i), stall_of(i), cnt_m[i]);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic fin, fout;
            fin  = in_valid[i] && model_ready(i);
            fout = (mq[i].size() > 0) && out_ready[i];
            if (!flush[i] && mq[i].size() > 0 && !out_ready[i] && cnt_m[i] < cnt_cap[i])
                cnt_m[i]++;
            if (flush[i]) begin
                mq[i].delete();
            end else begin
                if (fout) void'(mq[i].pop_front());
                if (fin) mq[i].push_back(in_data[i]);
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs compared at the following negedge.
    task automatic tick(input string ph);
        @(negedge clk);
        compare_all(ph);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
            flush[i]     = 1'b0;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cnt_cap[0] = 32'hFFFF_FFFF;
        cnt_cap[1] = 32'hFFFF_FFFF;
        cnt_cap[2] = 15;
        model_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ir", 32'(in_ready[i]), 32'd1);
            check("rst_ov", 32'(out_valid[i]), 32'd0);
            check("rst_data", 32'(out_data[i]), 32'd0);
            check("rst_occ", 32'(occ[i]), 32'd0);
            check("rst_stall", stall_of(i), 32'd0);
        end
        reset = 1'b0;

        // Streaming through the skid instance.
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[0] = 16'((k + 1) * 16'h11);
            tick("strm");
            check("strm_data", 32'(out_data[0]), 32'((k + 1) * 16'h11));
            check("strm_ir", 32'(in_ready[0]), 32'd1);
        end
        in_valid[0] = 1'b0;
        tick("strm");

        // Back-pressure: two beats held, in_ready drops, five stall cycles.
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h000A;
        tick("bp");
        in_data[0] = 16'h000B;
        tick("bp");
        in_valid[0] = 1'b0;
        check("bp_occ", 32'(occ[0]), 32'd2);
        check("bp_ir", 32'(in_ready[0]), 32'd0);
        repeat (4) tick("bp");
        check("bp_stall5", st_skid, 32'd5);
        out_ready[0] = 1'b1;
        #1;
        check("bp_first", 32'(out_data[0]), 32'h000A);
        tick("bp");
        check("bp_second", 32'(out_data[0]), 32'h000B);
        check("bp_second_ov", 32'(out_valid[0]), 32'd1);
        tick("bp");
        check("bp_drained", 32'(out_valid[0]), 32'd0);

        // Flush with two beats held and a beat presented in the same cycle.
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0001;
        tick("fl");
        in_data[0] = 16'h0002;
        tick("fl");
        flush[0]   = 1'b1;
        in_data[0] = 16'h000C;
        tick("fl");
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("fl_ov", 32'(out_valid[0]), 32'd0);
        check("fl_occ", 32'(occ[0]), 32'd0);
        out_ready[0] = 1'b1;
        repeat (3) begin
            tick("fl");
            check("fl_no_c", 32'(out_valid[0]), 32'd0);
        end

        // Single-register mode: combinational in_ready and same-cycle replacement.
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = 16'h0005;
        tick("s0");
        in_data[1] = 16'h0006;
        #1;
        check("s0_ir_low", 32'(in_ready[1]), 32'd0);
        out_ready[1] = 1'b1;
        #1;
        check("s0_ir_high", 32'(in_ready[1]), 32'd1);
        tick("s0");
        check("s0_replace", 32'(out_data[1]), 32'h0006);
        check("s0_ov", 32'(out_valid[1]), 32'd1);
        in_valid[1] = 1'b0;
        tick("s0");

        // Saturation of the 4-bit counter.
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_data[2]   = 16'h0007;
        tick("sat");
        in_valid[2] = 1'b0;
        repeat (20) tick("sat");
        check("sat_15", 32'(st_sat), 32'd15);
        repeat (3) tick("sat");
        check("sat_hold", 32'(st_sat), 32'd15);
        out_ready[2] = 1'b1;
        tick("sat");

        // Randomized traffic on all three instances.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                in_data[i]   = 16'($urandom);
                out_ready[i] = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
                flush[i]     = ($urandom_range(0, 31) == 0);
            end
            tick("rnd");
        end

        // Asynchronous reset with two beats held in the skid instance.
        idle_inputs();
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h00E1;
        tick("ar");
        in_data[0] = 16'h00E2;
        tick("ar");
        in_valid[0] = 1'b0;
        check("ar_pre_occ", 32'(occ[0]), 32'd2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ov", 32'(out_valid[0]), 32'd0);
        check("ar_occ", 32'(occ[0]), 32'd0);
        check("ar_data", 32'(out_data[0]), 32'd0);
        check("ar_stall", st_skid, 32'd0);
        check("ar_ir", 32'(in_ready[0]), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
